// File: rtl/mux_serializer_pkg.sv
// rtl/mux_serializer_pkg.sv - shared types and constants for the mux serializer
package mux_ser_pkg;

   localparam int WORD_W = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef logic [0:SEL_W-1]  sel_t;
   typedef logic [0:WORD_W-1] word_t;

   // Select value of the first bit sent, and of the last one, for a given bit order
   function automatic sel_t first_sel(input bit lsb_first);
      return lsb_first ? sel_t'(WORD_W - 1) : sel_t'(0);
   endfunction

   function automatic sel_t last_sel(input bit lsb_first);
      return lsb_first ? sel_t'(0) : sel_t'(WORD_W - 1);
   endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// rtl/mux_serializer_if.sv - load and serial-bit handshake bundle
interface mux_serializer_if;
   import mux_ser_pkg::*;

   logic  load_valid;
   logic  load_ready;
   word_t load_data;
   logic  bit_out;
   logic  bit_valid;
   logic  bit_last;
   logic  bit_ready;

   modport master (
      output load_valid, load_data, bit_ready,
      input  load_ready, bit_out, bit_valid, bit_last
   );

   modport slave (
      input  load_valid, load_data, bit_ready,
      output load_ready, bit_out, bit_valid, bit_last
   );

endinterface

// File: rtl/mux_serializer_mux8.sv
// rtl/mux_serializer_mux8.sv - 8:1 bit mux, index 0 is the leftmost word bit
module mux_serializer_mux8
   import mux_ser_pkg::*;
(
   input  word_t data_i,
   input  sel_t  sel_i,
   output logic  y_o
);

   assign y_o = data_i[sel_i];

endmodule

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - parallel word to serial bit stream through an 8:1 mux
module mux_serializer
   import mux_ser_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   mux_serializer_if.slave io,
   output sel_t            sel,
   output logic [7:0]      word_count
);

   localparam sel_t FIRST_SEL = first_sel(LSB_FIRST);
   localparam sel_t LAST_SEL  = last_sel(LSB_FIRST);

   state_t     state_q, state_d;
   sel_t       sel_q, sel_d;
   word_t      word_q, word_d;
   logic [7:0] count_q, count_d;
   logic       is_last, bit_fire, load_fire, mux_bit;

   assign is_last   = (sel_q == LAST_SEL);
   assign bit_fire  = (state_q == SEND) && io.bit_ready;
   assign load_fire = io.load_valid && io.load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= FIRST_SEL;
         word_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         word_q  <= word_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = IDLE;
      else if (load_fire)
         state_d = SEND;
      else if (bit_fire && is_last)
         state_d = IDLE;
   end

   // Stepping past the last select wraps back to the first one in 3 bits
   always_comb begin
      sel_d   = sel_q;
      word_d  = word_q;
      count_d = count_q;
      if (flush) begin
         sel_d  = FIRST_SEL;
         word_d = '0;
      end else begin
         if (bit_fire && is_last)
            count_d = count_q + 8'd1;
         if (load_fire) begin
            word_d = io.load_data;
            sel_d  = FIRST_SEL;
         end else if (bit_fire) begin
            sel_d = LSB_FIRST ? sel_q - sel_t'(1) : sel_q + sel_t'(1);
         end
      end
   end

   always_comb begin
      io.bit_valid  = (state_q == SEND);
      io.bit_last   = (state_q == SEND) && is_last;
      io.load_ready = !rst && !flush &&
                      ((state_q == IDLE) || (is_last && io.bit_ready));
   end

   mux_serializer_mux8 u_mux (
      .data_i (word_q),
      .sel_i  (sel_q),
      .y_o    (mux_bit)
   );

   assign io.bit_out = mux_bit;
   assign sel        = sel_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - self-checking bench for both bit orders of mux_serializer
module tb_mux_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [0:2] sel0, sel1;
   logic [7:0] wc0, wc1;
   int         passed = 0;
   int         total = 0;
   int         exp_cnt0 = 0;
   int         exp_cnt1 = 0;

   mux_serializer_if if0 ();
   mux_serializer_if if1 ();

   mux_serializer #(.LSB_FIRST(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .io(if0), .sel(sel0), .word_count(wc0)
   );

   mux_serializer #(.LSB_FIRST(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush), .io(if1), .sel(sel1), .word_count(wc1)
   );

   always #5 clk = ~clk;

   // Reference: position pos of a word, counted from the first bit sent
   function automatic logic exp_bit(input logic [7:0] w, input int pos, input bit lsb);
      int k;
      k = lsb ? 7 - pos : pos;
      return w[7-k];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      #1;
      total += 6;
      if (if0.load_ready !== 1'b0) $display("FAIL reset_load_ready: got %0b want 0", if0.load_ready); else passed++;
      if (if0.bit_valid !== 1'b0) $display("FAIL reset_bit_valid: got %0b want 0", if0.bit_valid); else passed++;
      if (if0.bit_last !== 1'b0) $display("FAIL reset_bit_last: got %0b want 0", if0.bit_last); else passed++;
      if (wc0 !== 8'd0) $display("FAIL reset_word_count: got %0d want 0", wc0); else passed++;
      if (sel0 !== 3'd0) $display("FAIL reset_sel_msb: got %0d want 0", sel0); else passed++;
      if (sel1 !== 3'd7) $display("FAIL reset_sel_lsb: got %0d want 7", sel1); else passed++;
      tick();
      rst = 1'b0;
      #1;
      total += 2;
      if (if0.load_ready !== 1'b1) $display("FAIL release_ready0: got %0b want 1", if0.load_ready); else passed++;
      if (if1.load_ready !== 1'b1) $display("FAIL release_ready1: got %0b want 1", if1.load_ready); else passed++;
      tick();
   endtask

   task automatic test_single_word();
      logic [7:0] w = 8'b10110001;
      if0.load_valid = 1'b1;
      if0.load_data  = w;
      if0.bit_ready  = 1'b1;
      tick();
      if0.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         total += 4;
         if (if0.bit_valid !== 1'b1) $display("FAIL single_valid[%0d]: got %0b want 1", i, if0.bit_valid); else passed++;
         if (if0.bit_out !== exp_bit(w, i, 1'b0)) $display("FAIL single_bit[%0d]: got %0b want %0b", i, if0.bit_out, exp_bit(w, i, 1'b0)); else passed++;
         if (sel0 !== 3'(i)) $display("FAIL single_sel[%0d]: got %0d want %0d", i, sel0, i); else passed++;
         if (if0.bit_last !== (i == 7)) $display("FAIL single_last[%0d]: got %0b want %0b", i, if0.bit_last, (i == 7)); else passed++;
         tick();
      end
      exp_cnt0++;
      #1;
      total += 2;
      if (if0.bit_valid !== 1'b0) $display("FAIL single_idle: got %0b want 0", if0.bit_valid); else passed++;
      if (wc0 !== 8'(exp_cnt0)) $display("FAIL single_count: got %0d want %0d", wc0, exp_cnt0); else passed++;
      tick();
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      for (int n = 0; n < 3; n++) begin
         w = (n == 0) ? 8'b10110001 : 8'($urandom);
         if1.load_valid = 1'b1;
         if1.load_data  = w;
         if1.bit_ready  = 1'b1;
         tick();
         if1.load_valid = 1'b0;
         for (int i = 0; i < 8; i++) begin
            #1;
            total += 3;
            if (if1.bit_out !== exp_bit(w, i, 1'b1)) $display("FAIL lsb_bit[%0d.%0d]: got %0b want %0b", n, i, if1.bit_out, exp_bit(w, i, 1'b1)); else passed++;
            if (sel1 !== 3'(7 - i)) $display("FAIL lsb_sel[%0d.%0d]: got %0d want %0d", n, i, sel1, 7 - i); else passed++;
            if (if1.bit_last !== (i == 7)) $display("FAIL lsb_last[%0d.%0d]: got %0b want %0b", n, i, if1.bit_last, (i == 7)); else passed++;
            tick();
         end
         exp_cnt1++;
      end
      if1.bit_ready = 1'b0;
      #1;
      total += 1;
      if (wc1 !== 8'(exp_cnt1)) $display("FAIL lsb_count: got %0d want %0d", wc1, exp_cnt1); else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] w = 8'($urandom);
      int pos = 0;
      int cyc = 0;
      int stalls = 0;
      if0.load_valid = 1'b1;
      if0.load_data  = w;
      if0.bit_ready  = 1'b1;
      tick();
      if0.load_valid = 1'b0;
      while (pos < 8 && cyc < 40) begin
         if (pos == 3 && stalls < 3) begin
            if0.bit_ready = 1'b0;
            stalls++;
         end else begin
            if0.bit_ready = 1'b1;
         end
         #1;
         cyc++;
         total += 3;
         if (if0.bit_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b want 1", cyc, if0.bit_valid); else passed++;
         if (if0.bit_out !== exp_bit(w, pos, 1'b0)) $display("FAIL bp_bit[%0d]: got %0b want %0b", cyc, if0.bit_out, exp_bit(w, pos, 1'b0)); else passed++;
         if (sel0 !== 3'(pos)) $display("FAIL bp_sel[%0d]: got %0d want %0d", cyc, sel0, pos); else passed++;
         if (if0.bit_ready) pos++;
         tick();
      end
      exp_cnt0++;
      if0.bit_ready = 1'b1;
      #1;
      total += 3;
      if (cyc !== 11) $display("FAIL bp_cycles: got %0d want 11", cyc); else passed++;
      if (if0.bit_valid !== 1'b0) $display("FAIL bp_idle: got %0b want 0", if0.bit_valid); else passed++;
      if (wc0 !== 8'(exp_cnt0)) $display("FAIL bp_count: got %0d want %0d", wc0, exp_cnt0); else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      if0.load_valid = 1'b1;
      if0.load_data  = 8'hFF;
      if0.bit_ready  = 1'b1;
      tick();
      if0.load_data = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) if0.load_valid = 1'b0;
         #1;
         total += 2;
         if (if0.bit_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %0b want 1", i, if0.bit_valid); else passed++;
         if (if0.bit_out !== (i < 8)) $display("FAIL b2b_bit[%0d]: got %0b want %0b", i, if0.bit_out, (i < 8)); else passed++;
         if (i == 7) begin
            total++;
            if (if0.load_ready !== 1'b1) $display("FAIL b2b_ready: got %0b want 1", if0.load_ready); else passed++;
         end
         tick();
      end
      exp_cnt0 += 2;
      #1;
      total += 2;
      if (if0.bit_valid !== 1'b0) $display("FAIL b2b_idle: got %0b want 0", if0.bit_valid); else passed++;
      if (wc0 !== 8'(exp_cnt0)) $display("FAIL b2b_count: got %0d want %0d", wc0, exp_cnt0); else passed++;
      tick();
   endtask

   task automatic test_flush();
      if0.load_valid = 1'b1;
      if0.load_data  = 8'($urandom);
      if0.bit_ready  = 1'b1;
      tick();
      if0.load_valid = 1'b0;
      repeat (4) tick();
      flush = 1'b1;
      if0.load_valid = 1'b1;
      if0.load_data  = 8'($urandom);
      #1;
      total += 2;
      if (sel0 !== 3'd4) $display("FAIL flush_at_sel: got %0d want 4", sel0); else passed++;
      if (if0.load_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", if0.load_ready); else passed++;
      tick();
      flush = 1'b0;
      if0.load_valid = 1'b0;
      #1;
      total += 3;
      if (if0.bit_valid !== 1'b0) $display("FAIL flush_idle: got %0b want 0", if0.bit_valid); else passed++;
      if (sel0 !== 3'd0) $display("FAIL flush_sel: got %0d want 0", sel0); else passed++;
      if (wc0 !== 8'(exp_cnt0)) $display("FAIL flush_count: got %0d want %0d", wc0, exp_cnt0); else passed++;
      tick();
   endtask

   task automatic test_random();
      logic [7:0] words[8];
      logic       exp_q[$];
      logic       last_q[$];
      int offer = 0;
      int got = 0;
      int cyc = 0;
      logic lf;
      for (int n = 0; n < 8; n++) begin
         words[n] = 8'($urandom);
         for (int p = 0; p < 8; p++) begin
            exp_q.push_back(exp_bit(words[n], p, 1'b0));
            last_q.push_back(p == 7);
         end
      end
      while (got < 64 && cyc < 2000) begin
         if (offer < 8) begin
            if0.load_valid = ($urandom_range(0, 3) != 0);
            if0.load_data  = words[offer];
         end else begin
            if0.load_valid = 1'b0;
         end
         if0.bit_ready = ($urandom_range(0, 3) != 0);
         #1;
         cyc++;
         lf = if0.load_valid && if0.load_ready;
         if (if0.bit_valid && if0.bit_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL rnd_extra_bit: got a bit with none expected");
            end else begin
               if (if0.bit_out !== exp_q[0] || if0.bit_last !== last_q[0])
                  $display("FAIL rnd_bit[%0d]: got %0b/%0b want %0b/%0b", got, if0.bit_out, if0.bit_last, exp_q[0], last_q[0]);
               else
                  passed++;
               void'(exp_q.pop_front());
               void'(last_q.pop_front());
            end
            got++;
         end
         if (lf) offer++;
         tick();
      end
      exp_cnt0 += 8;
      if0.load_valid = 1'b0;
      if0.bit_ready  = 1'b0;
      #1;
      total += 2;
      if (got !== 64) $display("FAIL rnd_bits_seen: got %0d want 64", got); else passed++;
      if (wc0 !== 8'(exp_cnt0)) $display("FAIL rnd_count: got %0d want %0d", wc0, exp_cnt0); else passed++;
      tick();
   endtask

   task automatic test_reset_mid_word();
      if0.load_valid = 1'b1;
      if0.load_data  = 8'($urandom);
      if0.bit_ready  = 1'b1;
      tick();
      if0.load_valid = 1'b0;
      repeat (2) tick();
      #1;
      total += 2;
      if (sel0 !== 3'd2) $display("FAIL rstmid_sel_before: got %0d want 2", sel0); else passed++;
      if (if0.bit_valid !== 1'b1) $display("FAIL rstmid_valid_before: got %0b want 1", if0.bit_valid); else passed++;
      #2;
      rst = 1'b1;
      #1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      total += 4;
      if (if0.bit_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", if0.bit_valid); else passed++;
      if (sel0 !== 3'd0) $display("FAIL rstmid_sel: got %0d want 0", sel0); else passed++;
      if (wc0 !== 8'd0) $display("FAIL rstmid_count: got %0d want 0", wc0); else passed++;
      if (if0.load_ready !== 1'b0) $display("FAIL rstmid_ready: got %0b want 0", if0.load_ready); else passed++;
      @(posedge clk);
      #3;
      total++;
      if (if0.bit_valid !== 1'b0) $display("FAIL rstmid_valid_held: got %0b want 0", if0.bit_valid); else passed++;
      rst = 1'b0;
      #1;
      total += 3;
      if (if0.load_ready !== 1'b1) $display("FAIL rstmid_release_ready: got %0b want 1", if0.load_ready); else passed++;
      if (wc0 !== 8'd0) $display("FAIL rstmid_release_count: got %0d want 0", wc0); else passed++;
      if (wc1 !== 8'd0) $display("FAIL rstmid_release_count1: got %0d want 0", wc1); else passed++;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      if0.load_valid = 1'b0;
      if0.load_data  = '0;
      if0.bit_ready  = 1'b0;
      if1.load_valid = 1'b0;
      if1.load_data  = '0;
      if1.bit_ready  = 1'b0;
      test_reset();
      test_single_word();
      test_lsb_first();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_mid_word();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mux_serializer.md
MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 0; 0 = send word bit index 0 first (sel 0->7), 1 = send bit index 7 first (sel 7->0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load_valid  input  1  upstream offers a word on load_data.
REQ-005 load_ready  output  1  block accepts a word this cycle.
REQ-006 load_data  input  [0:7]  parallel word; index 0 is the leftmost bit.
REQ-007 flush  input  1  synchronous abort of the word in progress.
REQ-008 bit_out  output  1  serial data bit, equal to the 8:1 mux output.
REQ-009 bit_valid  output  1  bit_out is valid.
REQ-010 bit_last  output  1  current bit is the final bit of the word.
REQ-011 bit_ready  input  1  downstream consumes bit_out this cycle.
REQ-012 sel  output  [0:2]  current mux select, exported for debug.
REQ-013 word_count  output  8  number of words fully sent, modulo 256.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-015 Load handshake: a word SHALL transfer when load_valid && load_ready.
REQ-016 load_ready SHALL be 1 in IDLE, 1 in SEND during the last-bit cycle when bit_ready=1, 0 otherwise, and 0 while rst=1.
REQ-017 On transfer, the word SHALL be captured into a register, sel SHALL be set to 000 (LSB_FIRST=0) or 111 (LSB_FIRST=1), and the state SHALL be SEND in the next cycle.
REQ-018 bit_out SHALL equal word[sel], combinationally via the mux, with zero-cycle latency from sel.
REQ-019 bit_valid SHALL be 1 exactly when state is SEND.
REQ-020 Bit handshake: a bit transfers when bit_valid && bit_ready; sel SHALL advance by one step (+1 or -1 per LSB_FIRST) only on a bit transfer, and SHALL hold otherwise.
REQ-021 bit_last SHALL be 1 when in SEND and sel is 111 (LSB_FIRST=0) or 000 (LSB_FIRST=1).
REQ-022 A transfer of the last bit SHALL increment word_count (wrapping 255->0) and move to IDLE, unless a load transfers in the same cycle.
REQ-023 Back-to-back: if the last bit transfers and a load transfers in the same cycle, the block SHALL stay in SEND with the new word and reset sel, with no bubble cycle.
REQ-024 flush=1 SHALL put the state in IDLE next cycle, discard the current word, reset sel, and leave word_count unchanged.
REQ-025 flush SHALL take priority over load and bit transfers in the same cycle; load_ready SHALL be 0 while flush=1.
REQ-026 A complete word SHALL take exactly 8 bit transfers; bit_ready stalls SHALL add latency only.

Reset
REQ-027 While rst=1, the block SHALL hold state IDLE, sel 000 (LSB_FIRST=0) or 111 (LSB_FIRST=1), word register 0, word_count 0, bit_valid 0, bit_last 0, and load_ready 0.
REQ-028 A reset asserted in SEND SHALL abort the word immediately (asynchronously), and no bit_valid SHALL be seen after the assertion.
REQ-029 After rst deasserts, load_ready SHALL be 1 in the first cycle.

Structure
REQ-030 A shared package mux_ser_pkg SHALL hold the state enum (IDLE, SEND), WORD_W=8, and SEL_W=3.
REQ-031 The team's existing 8:1 mux module SHALL be instantiated as the sole sub-module, driven by the word register and sel.

Verification
REQ-032 Single word: load 8'b10110001 with LSB_FIRST=0 and bit_ready held at 1 -> bit_out sequence 1,0,1,1,0,0,0,1 on 8 consecutive cycles, bit_last on the 8th, then word_count=1.
REQ-033 LSB_FIRST=1: load 8'b10110001 -> bit_out sequence 1,0,0,0,1,1,0,1, with sel stepping 7 down to 0.
REQ-034 Backpressure: bit_ready=0 for 3 cycles at sel=011 -> sel and bit_out hold, and the word completes in 11 cycles.
REQ-035 Back-to-back: load_valid held with 8'hFF then 8'h00 -> 16 consecutive valid bits (eight 1s, eight 0s), no gap, and word_count=2.
REQ-036 Flush: flush at sel=100 while load_valid=1 -> IDLE next cycle, load not accepted that cycle, and word_count unchanged.
REQ-037 Reset mid-word: assert rst at sel=010 -> bit_valid=0 immediately, and after release load_ready=1 with word_count=0.
